// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator sequencer and the 16-bit ALU it feeds:
// opcode encodings, sequencer state type and the default datapath width.
package alu_pkg;

    localparam int ALU_W = 16;

    localparam logic [2:0] OP_NEG    = 3'b000;
    localparam logic [2:0] OP_INC    = 3'b001;
    localparam logic [2:0] OP_ADC    = 3'b010;
    localparam logic [2:0] OP_ADDSHR = 3'b011;
    localparam logic [2:0] OP_AND    = 3'b100;
    localparam logic [2:0] OP_OR     = 3'b101;
    localparam logic [2:0] OP_CAT    = 3'b110;
    localparam logic [2:0] OP_CLR    = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_acc_sequencer_if.sv
// Command and response handshakes of the accumulator sequencer.
// master = command source / response consumer, slave = the sequencer.
interface alu_acc_sequencer_if
    import alu_pkg::*;
#(
    parameter int W = ALU_W
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_opc;
    logic [W-1:0] cmd_operand;
    logic         cmd_load;
    logic         cmd_use_carry;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_zer;
    logic         rsp_neg;

    modport master (
        output cmd_valid, cmd_opc, cmd_operand, cmd_load, cmd_use_carry, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_zer, rsp_neg
    );

    modport slave (
        input  cmd_valid, cmd_opc, cmd_operand, cmd_load, cmd_use_carry, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_zer, rsp_neg
    );

endinterface

// File: rtl/alu_acc_sequencer.sv
// Command sequencer + accumulator placed in front of the 16-bit ALU.
// Accepts one command at a time, drives the ALU with the accumulator as
// operand A, captures the result and flags, and returns a response.
// Optional build macro: ALU_ACC_SAT_EN -- add-with-carry saturates to
// all-ones on carry-out instead of wrapping.
module alu_acc_sequencer
    import alu_pkg::*;
#(
    parameter int           W       = ALU_W,
    parameter logic [W-1:0] ACC_RST = '0
)
(
    input  logic             clk,
    input  logic             rst_n,
    alu_acc_sequencer_if.slave bus,
    output logic [W-1:0]     alu_inA,
    output logic [W-1:0]     alu_inB,
    output logic             alu_inC,
    output logic [2:0]       alu_opc,
    input  logic [W-1:0]     alu_outW,
    input  logic             alu_zer,
    input  logic             alu_neg,
    output logic             carry_flag
);

    seq_state_t   state_reg;
    logic [W-1:0] acc_reg;
    logic         carry_reg;
    logic [2:0]   opc_reg;
    logic [W-1:0] operand_reg;
    logic         use_carry_reg;
    logic         cmd_ready_reg;
    logic         rsp_valid_reg;
    logic         rsp_zer_reg;
    logic         rsp_neg_reg;

    logic         carry_in;
    logic [W:0]   adc_sum;

    logic [W-1:0] exec_acc_next;
    logic         exec_zer_next;
    logic         exec_neg_next;
    logic         exec_carry_next;

    // The ALU sees the registered command for the whole EXEC cycle; the
    // same values sit on the bus harmlessly in IDLE and RESP.
    assign carry_in = use_carry_reg & carry_reg;
    assign alu_inA  = acc_reg;
    assign alu_inB  = operand_reg;
    assign alu_inC  = carry_in;
    assign alu_opc  = opc_reg;

    // Local carry-out of the add-with-carry; the ALU does not report it.
    assign adc_sum = {1'b0, acc_reg} + {1'b0, operand_reg} + {{W{1'b0}}, carry_in};

    assign carry_flag    = carry_reg;
    assign bus.cmd_ready = cmd_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = acc_reg;
    assign bus.rsp_zer   = rsp_zer_reg;
    assign bus.rsp_neg   = rsp_neg_reg;

    // Values captured at the end of EXEC: ALU result/flags plus carry tracking.
    always_comb begin
        exec_acc_next   = alu_outW;
        exec_zer_next   = alu_zer;
        exec_neg_next   = alu_neg;
        exec_carry_next = carry_reg;
        case (opc_reg)
            OP_NEG: exec_carry_next = (acc_reg == '0);
            OP_INC: exec_carry_next = (acc_reg == '1);
            OP_ADC: begin
                exec_carry_next = adc_sum[W];
`ifdef ALU_ACC_SAT_EN
                if (adc_sum[W]) begin
                    exec_acc_next = '1;
                    exec_zer_next = 1'b0;
                    exec_neg_next = 1'b1;
                end
`endif
            end
            default: exec_carry_next = carry_reg;
        endcase
    end

    // IDLE -> (EXEC) -> RESP -> IDLE sequencer with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            acc_reg       <= ACC_RST;
            carry_reg     <= 1'b0;
            opc_reg       <= '0;
            operand_reg   <= '0;
            use_carry_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_zer_reg   <= (ACC_RST == '0);
            rsp_neg_reg   <= ACC_RST[W-1];
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_reg) begin
                        opc_reg       <= bus.cmd_opc;
                        operand_reg   <= bus.cmd_operand;
                        use_carry_reg <= bus.cmd_use_carry;
                        cmd_ready_reg <= 1'b0;
                        if (bus.cmd_load) begin
                            // Loads bypass the ALU; flags come straight from the value.
                            acc_reg       <= bus.cmd_operand;
                            rsp_zer_reg   <= (bus.cmd_operand == '0);
                            rsp_neg_reg   <= bus.cmd_operand[W-1];
                            rsp_valid_reg <= 1'b1;
                            state_reg     <= RESP;
                        end else begin
                            state_reg     <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    acc_reg       <= exec_acc_next;
                    rsp_zer_reg   <= exec_zer_next;
                    rsp_neg_reg   <= exec_neg_next;
                    carry_reg     <= exec_carry_next;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_reg <= 1'b0;
                    cmd_ready_reg <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Testbench for alu_acc_sequencer: directed vector table, hand-written
// back-pressure and async-reset sequences, then randomized commands
// checked against an arithmetic reference model. Honours ALU_ACC_SAT_EN.
module tb_alu_acc_sequencer;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] alu_inA, alu_inB, alu_outW;
    logic        alu_inC, alu_zer, alu_neg, carry_flag;
    logic [2:0]  alu_opc;

    int checks = 0;
    int errors = 0;

    alu_acc_sequencer_if #(.W(16)) bus ();

    alu_acc_sequencer #(.W(16), .ACC_RST(16'h0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_inA    (alu_inA),
        .alu_inB    (alu_inB),
        .alu_inC    (alu_inC),
        .alu_opc    (alu_opc),
        .alu_outW   (alu_outW),
        .alu_zer    (alu_zer),
        .alu_neg    (alu_neg),
        .carry_flag (carry_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the team's ALU.
    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic c);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (op)
            OP_NEG:    return (~a) + 16'd1;
            OP_INC:    return a + 16'd1;
            OP_ADC:    return a + b + {15'd0, c};
            OP_ADDSHR: return s[16:1];
            OP_AND:    return a & b;
            OP_OR:     return a | b;
            OP_CAT:    return {a[7:0], b[7:0]};
            default:   return 16'h0000;
        endcase
    endfunction

    assign alu_outW = alu_fn(alu_opc, alu_inA, alu_inB, alu_inC);
    assign alu_zer  = (alu_outW == 16'h0000);
    assign alu_neg  = alu_outW[15];

    // Reference model: plain integer arithmetic on the accumulator and carry.
    int m_acc   = 0;
    int m_carry = 0;

    task automatic model_step(input bit ld, input int op, input int b, input bit uc);
        int a, s, r, cin;
        a   = m_acc;
        cin = (uc && m_carry != 0) ? 1 : 0;
        r   = a;
        if (ld) begin
            r = b;
        end else begin
            case (op)
                0: begin r = (65536 - a) % 65536; m_carry = (a == 0) ? 1 : 0; end
                1: begin r = (a + 1) % 65536;     m_carry = (a == 65535) ? 1 : 0; end
                2: begin
                    s = a + b + cin;
                    r = s % 65536;
                    m_carry = (s >= 65536) ? 1 : 0;
`ifdef ALU_ACC_SAT_EN
                    if (s >= 65536) r = 65535;
`endif
                end
                3: r = (a + b) / 2;
                4: r = a & b;
                5: r = a | b;
                6: r = (a % 256) * 256 + (b % 256);
                default: r = 0;
            endcase
        end
        m_acc = r;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Runs one command; must be entered #1 after a rising edge with the DUT idle.
    task automatic run_txn(input bit ld, input logic [2:0] op, input logic [15:0] opd,
                           input bit uc, input int stall,
                           output logic [15:0] d, output logic z, output logic n,
                           output logic c, output int lat);
        int guard;
        bus.rsp_ready     = (stall == 0);
        bus.cmd_valid     = 1'b1;
        bus.cmd_load      = ld;
        bus.cmd_opc       = op;
        bus.cmd_operand   = opd;
        bus.cmd_use_carry = uc;
        guard = 0;
        while (!bus.cmd_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 20) check("cmd_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
        d = bus.rsp_data;
        z = bus.rsp_zer;
        n = bus.rsp_neg;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_data_stable", {16'd0, bus.rsp_data}, {16'd0, d});
            check("stall_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        c = carry_flag;
        check("post_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("post_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        $display("TXN ld=%0d opc=%0d opd=%h uc=%0d stall=%0d -> data=%h zer=%0d neg=%0d carry=%0d lat=%0d",
                 ld, op, opd, uc, stall, d, z, n, c, lat);
    endtask

    typedef struct {
        logic        ld;
        logic [2:0]  op;
        logic [15:0] opd;
        logic        uc;
        logic [15:0] data;
        logic        zer;
        logic        neg;
        logic        carry;
    } vec_t;

    vec_t vecs[20];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d, snap;
        logic        z, n, c;
        int          lat, guard, stall;
        bit          ld, uc;
        logic [2:0]  op;
        logic [15:0] opd;

        vecs[0]  = '{1'b1, OP_NEG,    16'h7FFF, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, OP_INC,    16'h0000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, OP_NEG,    16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0};
`ifdef ALU_ACC_SAT_EN
        vecs[3]  = '{1'b0, OP_ADC,    16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b1};
`else
        vecs[3]  = '{1'b0, OP_ADC,    16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
`endif
        vecs[4]  = '{1'b1, OP_NEG,    16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, OP_ADC,    16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, OP_NEG,    16'h12AB, 1'b0, 16'h12AB, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, OP_CAT,    16'h00CD, 1'b0, 16'hABCD, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, OP_CLR,    16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, OP_NEG,    16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, OP_CLR,    16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, OP_NEG,    16'h0005, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, OP_NEG,    16'h0000, 1'b0, 16'hFFFB, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, OP_AND,    16'h00F0, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, OP_OR,     16'h0F00, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, OP_ADDSHR, 16'h0010, 1'b0, 16'h0800, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b1, OP_NEG,    16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{1'b0, OP_INC,    16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[18] = '{1'b0, OP_ADC,    16'h8000, 1'b1, 16'h8001, 1'b0, 1'b1, 1'b0};
`ifdef ALU_ACC_SAT_EN
        vecs[19] = '{1'b0, OP_ADC,    16'h8000, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b1};
`else
        vecs[19] = '{1'b0, OP_ADC,    16'h8000, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1};
`endif

        bus.cmd_valid     = 1'b0;
        bus.cmd_load      = 1'b0;
        bus.cmd_opc       = 3'b000;
        bus.cmd_operand   = 16'h0000;
        bus.cmd_use_carry = 1'b0;
        bus.rsp_ready     = 1'b1;
        rst_n             = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state.
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_carry",     {31'd0, carry_flag},    32'd0);
        check("rst_rsp_zer",   {31'd0, bus.rsp_zer},   32'd1);
        check("rst_rsp_data",  {16'd0, bus.rsp_data},  32'd0);

        // Directed vector table.
        for (int i = 0; i < 20; i++) begin
            run_txn(vecs[i].ld, vecs[i].op, vecs[i].opd, vecs[i].uc, 0, d, z, n, c, lat);
            model_step(vecs[i].ld, int'(vecs[i].op), int'(vecs[i].opd), vecs[i].uc);
            check($sformatf("vec%0d_data", i),  {16'd0, d}, {16'd0, vecs[i].data});
            check($sformatf("vec%0d_zer", i),   {31'd0, z}, {31'd0, vecs[i].zer});
            check($sformatf("vec%0d_neg", i),   {31'd0, n}, {31'd0, vecs[i].neg});
            check($sformatf("vec%0d_carry", i), {31'd0, c}, {31'd0, vecs[i].carry});
            check($sformatf("vec%0d_latency", i), lat, vecs[i].ld ? 32'd1 : 32'd2);
        end

        // Back-pressure: response held 5 cycles while a second command waits.
        bus.rsp_ready     = 1'b0;
        bus.cmd_valid     = 1'b1;
        bus.cmd_load      = 1'b0;
        bus.cmd_opc       = OP_INC;
        bus.cmd_operand   = 16'h0000;
        bus.cmd_use_carry = 1'b0;
        @(posedge clk); #1;
        model_step(1'b0, 1, 0, 1'b0);
        bus.cmd_load    = 1'b1;
        bus.cmd_operand = 16'h5A5A;
        guard = 0;
        while (!bus.rsp_valid && guard < 20) begin
            check("bp_cmd_ready_wait", {31'd0, bus.cmd_ready}, 32'd0);
            @(posedge clk); #1;
            guard++;
        end
        snap = bus.rsp_data;
        check("bp_first_data", {16'd0, snap}, m_acc);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_data_stable", {16'd0, bus.rsp_data}, {16'd0, snap});
            check("bp_cmd_ready",   {31'd0, bus.cmd_ready}, 32'd0);
            check("bp_rsp_valid",   {31'd0, bus.rsp_valid}, 32'd1);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_handshake_ready", {31'd0, bus.cmd_ready}, 32'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        model_step(1'b1, 0, 16'h5A5A, 1'b0);
        check("bp_second_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("bp_second_data",  {16'd0, bus.rsp_data}, 32'h5A5A);
        @(posedge clk); #1;
        $display("TXN backpressure first=%h second=%h", snap, 16'h5A5A);

        // Async reset while EXEC: set acc and carry first so the reset is visible.
        run_txn(1'b1, OP_NEG, 16'hFFFF, 1'b0, 0, d, z, n, c, lat);
        run_txn(1'b0, OP_INC, 16'h0000, 1'b0, 0, d, z, n, c, lat);
        run_txn(1'b1, OP_NEG, 16'h1234, 1'b0, 0, d, z, n, c, lat);
        check("pre_rst_carry", {31'd0, carry_flag}, 32'd1);
        bus.cmd_valid   = 1'b1;
        bus.cmd_load    = 1'b0;
        bus.cmd_opc     = OP_INC;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("arst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("arst_rsp_data",  {16'd0, bus.rsp_data},  32'd0);
        check("arst_carry",     {31'd0, carry_flag},    32'd0);
        check("arst_rsp_zer",   {31'd0, bus.rsp_zer},   32'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        m_acc   = 0;
        m_carry = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("arst_no_rsp",  {31'd0, bus.rsp_valid}, 32'd0);
            check("arst_acc_hold", {16'd0, bus.rsp_data}, 32'd0);
        end
        $display("TXN async_reset_in_exec done");

        // Randomized commands against the reference model.
        for (int t = 0; t < 150; t++) begin
            ld    = ($urandom_range(0, 3) == 0);
            op    = 3'($urandom_range(0, 7));
            opd   = 16'($urandom);
            if ($urandom_range(0, 4) == 0) opd = 16'hFFFF;
            if ($urandom_range(0, 6) == 0) opd = 16'h0000;
            uc    = 1'($urandom_range(0, 1));
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            run_txn(ld, op, opd, uc, stall, d, z, n, c, lat);
            model_step(ld, int'(op), int'(opd), uc);
            check("rnd_data",    {16'd0, d}, m_acc);
            check("rnd_zer",     {31'd0, z}, (m_acc == 0) ? 32'd1 : 32'd0);
            check("rnd_neg",     {31'd0, n}, (m_acc >= 32768) ? 32'd1 : 32'd0);
            check("rnd_carry",   {31'd0, c}, m_carry);
            check("rnd_latency", lat, ld ? 32'd1 : 32'd2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
